mod_fetch_unit: RTL and testbench
=================================

# mod_fetch_unit

Instruction fetch stage of the MIPS core. Holds the program counter and drives the word address of the combinational instruction ROM. Registers each returned instruction with its PC+4 into the IF/ID pipeline register. Handles decode stalls, branch/jump redirects, and halts cleanly when the ROM signals end of program.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; bits [1:0] must be 0
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  decode cannot accept; hold PC and IF/ID contents
- redirect_valid  input  1  branch/jump resolved taken this cycle
- redirect_target  input  32  new byte PC; bits [1:0] ignored (treated as 0)
- rom_address  output  30  word address to ROM, = pc[31:2], combinational from PC register
- rom_instruction  input  32  ROM data for rom_address, same cycle
- rom_mem_end  input  1  ROM flag: rom_address is past the last program word
- if_id_instruction  output  32  registered instruction to decode
- if_id_pc_plus4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  if_id contents are a real instruction (0 = bubble)
- halted  output  1  fetch is in HALT state
- fetch_count  output  32  number of instructions issued to IF/ID since reset

## Operation
- Internal registers: pc[31:0]; state in {FETCH, HALT}; IF/ID register; fetch_count.
- Priority per clock edge: reset > redirect_valid > stall > normal fetch/halt.
- reset: pc=RESET_PC, state=FETCH, if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, fetch_count=0.
- redirect_valid=1 (any state, regardless of stall): pc={redirect_target[31:2],2'b00}, if_id_valid=0 (flush), state=FETCH. IF/ID data fields are held. fetch_count is unchanged.
- stall=1, no redirect: pc, state, all IF/ID fields and fetch_count hold.
- FETCH, no stall, no redirect, rom_mem_end=0:
  - if_id_instruction=rom_instruction
  - if_id_pc_plus4=pc+4
  - if_id_valid=1
  - pc=pc+4, with modulo 2^32 wrap
  - fetch_count+=1, with modulo 2^32 wrap
- FETCH, no stall, no redirect, rom_mem_end=1:
  - if_id_valid=0; pc holds
  - state=HALT
- HALT, no redirect: all registers hold except if_id_valid, which is forced to 0 when not stalled. halted=1 combinationally from state.
- HALT is left only by redirect or reset. This lets a taken branch still in flight from the last instructions pull fetch back into the program.
- No combinational path from stall or redirect to rom_address.

## Timing
- Fetch latency: 1 cycle. An instruction at PC p appears on if_id_* on the edge after rom_address = p>>2 is presented.
- Throughput: 1 instruction/cycle with no stall.
- Redirect penalty: 1 bubble. The edge that samples redirect writes if_id_valid=0. The next edge issues the instruction at the target.
- Stall asserted at edge k: IF/ID shows the same instruction through edge k. A new instruction issues on the first edge with stall=0.
- Halt: halted rises on the edge that samples rom_mem_end=1. No valid instruction is issued on or after that edge until a redirect.
- Simultaneous redirect and rom_mem_end: redirect wins, and state stays/returns to FETCH.
- Reset mid-stall, mid-halt or mid-redirect: reset values apply on that edge, with no residual valid.

## Test plan
- Reset, then free-run with the 44-word test ROM (rom_mem_end when address > 43) and stall=0:
  - if_id_valid=1 for 44 consecutive cycles
  - if_id_pc_plus4 goes 4,8,...,176
  - halted=1 on the next edge, fetch_count=44, if_id_valid=0 afterwards
- Stall asserted for 3 cycles while word 5 is in IF/ID:
  - if_id_instruction and if_id_pc_plus4 (24) are held for 3 cycles
  - word 6 issues on the first edge with stall=0
  - fetch_count does not advance while stalled
- redirect_valid=1 with target 32'h14 while PC=0x30:
  - next edge: if_id_valid=0, pc=0x14
  - following edge: word 5 issued with if_id_pc_plus4=0x18
- Redirect with stall=1 in the same cycle, target 32'h17:
  - pc=0x14 (low bits cleared)
  - if_id_valid=0 despite stall
- In HALT, redirect_valid=1 with target 0x8:
  - halted=0 next edge
  - word 2 issues the edge after that
  - fetch_count resumes incrementing
- Synchronous reset asserted during HALT and during stall:
  - on that edge pc=RESET_PC, if_id_valid=0, halted=0, fetch_count=0
  - an asynchronous reset pulse between edges has no effect

Source files
------------

// File: rtl/mod_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register, with stall, redirect flush and end-of-program halt.
module mod_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [29:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        rom_mem_end,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr_next;
  logic [31:0] pc_plus4_next;
  logic        valid_next;
  logic [31:0] count_next;
  logic        unused_target_bits;

  assign pc_plus4           = pc + 32'd4;
  assign rom_address        = pc[31:2];
  assign halted             = (state == HALT);
  assign unused_target_bits = ^redirect_target[1:0];

  // A redirect always wins over stall and flushes IF/ID; the data fields are
  // left as they were since a cleared valid already marks them dead.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = if_id_instruction;
    pc_plus4_next = if_id_pc_plus4;
    valid_next    = if_id_valid;
    count_next    = fetch_count;
    if (redirect_valid) begin
      pc_next    = {redirect_target[31:2], 2'b00};
      valid_next = 1'b0;
      state_next = FETCH;
    end else if (!stall) begin
      case (state)
        FETCH: begin
          if (rom_mem_end) begin
            valid_next = 1'b0;
            state_next = HALT;
          end else begin
            instr_next    = rom_instruction;
            pc_plus4_next = pc_plus4;
            valid_next    = 1'b1;
            pc_next       = pc_plus4;
            count_next    = fetch_count + 32'd1;
          end
        end
        HALT: valid_next = 1'b0;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      if_id_instruction <= 32'd0;
      if_id_pc_plus4    <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      if_id_instruction <= instr_next;
      if_id_pc_plus4    <= pc_plus4_next;
      if_id_valid       <= valid_next;
      fetch_count       <= count_next;
    end
  end

endmodule

// File: tb/tb_mod_fetch_unit.sv
// Self-checking bench for mod_fetch_unit: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of fetch.
module tb_mod_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [29:0] rom_address;
  logic [31:0] rom_instruction;
  logic        rom_mem_end;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;
  bit end_en = 1'b1;

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted;

  mod_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .rom_address       (rom_address),
    .rom_instruction   (rom_instruction),
    .rom_mem_end       (rom_mem_end),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 44-word test program; every word carries its address so each is distinct.
  function automatic logic [31:0] rom_word(input logic [29:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic rom_end_f(input logic [29:0] a);
    return end_en && (a > 30'd43);
  endfunction

  assign rom_instruction = rom_word(rom_address);
  assign rom_mem_end     = rom_end_f(rom_address);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
    end else if (rdr) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_halted = 1'b0;
    end else if (stl) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (rom_end_f(m_pc[31:2])) begin
      m_valid = 1'b0;
      m_halted = 1'b1;
    end else begin
      m_instr = rom_word(m_pc[31:2]);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic checkOutput();
    check_eq("rom_address", {2'b00, rom_address}, {2'b00, m_pc[31:2]});
    check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    check_eq("fetch_count", fetch_count, m_count);
    check_eq("if_id_instruction", if_id_instruction, m_instr);
    check_eq("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
    reset = rst;
    stall = stl;
    redirect_valid = rdr;
    redirect_target = tgt;
    model_step(rst, stl, rdr, tgt);
    @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("reset_valid", {31'd0, if_id_valid}, 32'd0);

    // Free run through the whole program and into HALT.
    for (int i = 0; i < 44; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("run_valid", {31'd0, if_id_valid}, 32'd1);
      check_eq("run_pc4", if_id_pc_plus4, 32'(4 * (i + 1)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("halt_rise", {31'd0, halted}, 32'd1);
    check_eq("halt_count", fetch_count, 32'd44);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("halt_valid", {31'd0, if_id_valid}, 32'd0);

    // Leave HALT by redirecting to word 2.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8);
    check_eq("unhalt", {31'd0, halted}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("unhalt_word2", if_id_instruction, rom_word(30'd2));
    check_eq("unhalt_count", fetch_count, 32'd45);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("word5_pc4", if_id_pc_plus4, 32'd24);

    // Stall three cycles with word 5 held in IF/ID.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("stall_pc4", if_id_pc_plus4, 32'd24);
      check_eq("stall_instr", if_id_instruction, rom_word(30'd5));
      check_eq("stall_count", fetch_count, 32'd48);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("after_stall", if_id_pc_plus4, 32'd28);

    // Advance to PC=0x30 and redirect back to 0x14.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("pc_0x30", {2'b00, rom_address}, 32'd12);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h14);
    check_eq("redir_flush", {31'd0, if_id_valid}, 32'd0);
    check_eq("redir_pc", {2'b00, rom_address}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("redir_word5", if_id_pc_plus4, 32'h18);

    // Redirect beats stall, and the low target bits are dropped.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h17);
    check_eq("redir_stall_pc", {2'b00, rom_address}, 32'd5);
    check_eq("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);

    // PC wraps modulo 2^32 when the end-of-program flag is out of the way.
    end_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc4", if_id_pc_plus4, 32'd4);
    end_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    // Random mix of stalls, redirects (some past the end) and resets.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_stl, r_rdr;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 99) < 2);
      r_stl = ($urandom_range(0, 99) < 25);
      r_rdr = ($urandom_range(0, 99) < 8);
      r_tgt = 32'($urandom_range(0, 50) * 4 + $urandom_range(0, 3));
      applyStimulus(r_rst, r_stl, r_rdr, r_tgt);
    end

    // Reset taken while halted (and stalled).
    for (int i = 0; i < 100 && !m_halted; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("reach_halt", {31'd0, halted}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("rst_halt_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_halt_count", fetch_count, 32'd0);
    check_eq("rst_halt_pc", {2'b00, rom_address}, 32'd0);

    // Reset taken mid-stall.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("rst_stall_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("rst_stall_count", fetch_count, 32'd0);

    // A reset pulse that misses every rising edge must be ignored.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("async_pulse_count", fetch_count, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
